vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//    Generates VGA raster timing from a single 50 MHz system clock. The
//    pixel clock is the system clock divided by two, and every other
//    system cycle is a "pixel tick" on which the raster advances by one
//    pixel. All raster outputs are registered on pixel ticks, so they
//    change together with the rising edge of vga_25clk and hold for two
//    system cycles.
//
// Ports:
//    I_50MHZ_CLK   in   1   system clock, all logic on its rising edge
//    I_RST_N       in   1   synchronous active-low reset
//    vga_25clk     out  1   pixel clock (system clock / 2)
//    O_HSYNC       out  1   horizontal sync, active low
//    O_VSYNC       out  1   vertical sync, active low
//    display_data  out  1   high while the current pixel is visible
//    draw_finish   out  1   one-pixel strobe on the first line after the
//                           visible area
//    O_PIX_X       out  10  visible column (0 outside the visible area)
//    O_PIX_Y       out  10  visible row (0 outside the visible area)
//    O_FRAME_CNT   out  16  completed-frame counter, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        I_50MHZ_CLK,
   input  logic        I_RST_N,
   output logic        vga_25clk,
   output logic        O_HSYNC,
   output logic        O_VSYNC,
   output logic        display_data,
   output logic        draw_finish,
   output logic [9:0]  O_PIX_X,
   output logic [9:0]  O_PIX_Y,
   output logic [15:0] O_FRAME_CNT
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_LO  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_LO  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   // ST_IDLE: out of reset, no pixel presented yet; the first tick shows
   // (0,0) without advancing. ST_RUN: each tick advances the raster.
   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        pix_tick;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic [9:0]  h_next;
   logic [9:0]  v_next;
   logic        hsync_next;
   logic        vsync_next;
   logic        visible_next;
   logic        finish_next;
   logic [15:0] frame_cnt;

   assign pix_tick    = ~vga_25clk;
   assign O_FRAME_CNT = frame_cnt;

   // State register. Reset drops back to ST_IDLE so the raster restarts
   // at (0,0) on the first tick after release, abandoning any frame in
   // progress.
   always_ff @(posedge I_50MHZ_CLK) begin
      if (!I_RST_N) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and next raster position. The counters always hold the
   // pixel currently on the outputs, so the outputs below are decoded from
   // these post-increment values and registered in the same tick.
   always_comb begin
      state_next = state;
      h_next     = h_cnt;
      v_next     = v_cnt;
      if (pix_tick) begin
         if (state == ST_IDLE) begin
            state_next = ST_RUN;
            h_next     = 10'd0;
            v_next     = 10'd0;
         end else if (h_cnt == H_LAST) begin
            h_next = 10'd0;
            if (v_cnt == V_LAST) begin
               v_next = 10'd0;
            end else begin
               v_next = v_cnt + 10'd1;
            end
         end else begin
            h_next = h_cnt + 10'd1;
         end
      end
   end

   // Decode the next raster position into sync, visibility and the
   // end-of-visible-frame strobe. The strobe sits on the first pixel of
   // line V_VISIBLE, which is never visible, so it cannot overlap
   // display_data.
   always_comb begin
      hsync_next   = 1'b1;
      vsync_next   = 1'b1;
      visible_next = 1'b0;
      finish_next  = 1'b0;
      if ((h_next >= H_SYNC_LO) && (h_next <= H_SYNC_HI)) begin
         hsync_next = 1'b0;
      end
      if ((v_next >= V_SYNC_LO) && (v_next <= V_SYNC_HI)) begin
         vsync_next = 1'b0;
      end
      if ((h_next < H_VIS) && (v_next < V_VIS)) begin
         visible_next = 1'b1;
      end
      if ((h_next == 10'd0) && (v_next == V_VIS)) begin
         finish_next = 1'b1;
      end
   end

   // Pixel clock divider plus all raster registers. Everything except the
   // divider only moves on pixel ticks, so it lines up with the rising
   // edge of vga_25clk. The frame counter is only written when a frame
   // completes.
   always_ff @(posedge I_50MHZ_CLK) begin
      if (!I_RST_N) begin
         vga_25clk    <= 1'b0;
         h_cnt        <= 10'd0;
         v_cnt        <= 10'd0;
         O_HSYNC      <= 1'b1;
         O_VSYNC      <= 1'b1;
         display_data <= 1'b0;
         draw_finish  <= 1'b0;
         O_PIX_X      <= 10'd0;
         O_PIX_Y      <= 10'd0;
         frame_cnt    <= 16'd0;
      end else begin
         vga_25clk <= ~vga_25clk;
         if (pix_tick) begin
            h_cnt        <= h_next;
            v_cnt        <= v_next;
            O_HSYNC      <= hsync_next;
            O_VSYNC      <= vsync_next;
            display_data <= visible_next;
            draw_finish  <= finish_next;
            O_PIX_X      <= visible_next ? h_next : 10'd0;
            O_PIX_Y      <= visible_next ? v_next : 10'd0;
            if (finish_next) begin
               frame_cnt <= frame_cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Purpose:
//    Self-checking bench for vga_timing_gen using a small raster
//    (16 x 10 totals, 8 x 6 visible) so several whole frames fit in a
//    short run. Outputs are compared every system cycle against a model
//    that derives the raster position from the number of pixel ticks
//    since reset release, plus a startup vector table and hand-written
//    measurements of sync timing, frame spacing, mid-frame reset and
//    frame-counter wrap.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int HV = 8;
   localparam int HF = 2;
   localparam int HS = 3;
   localparam int HB = 3;
   localparam int VV = 6;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int FIN_TICK = VV * HT;

   typedef struct packed {
      logic        vga;
      logic        hs;
      logic        vs;
      logic        de;
      logic        df;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [15:0] fc;
   } out_t;

   typedef struct {
      logic rst_n;
      out_t exp;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        vga_25clk;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic        df;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [15:0] frame_cnt;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [15:0] fc_base = 16'd0;

   bit          measure = 0;
   logic        prev_hs = 1'b1;
   logic        prev_vs = 1'b1;
   int          hs_fall[$];
   int          hs_rise[$];
   int          vs_fall[$];
   int          vs_rise[$];
   int          df_tick[$];
   int          de_counts[$];
   logic [19:0] last_pix[$];
   int          de_run = 0;
   logic [19:0] cur_last = 20'd0;

   vga_timing_gen #(
      .H_VISIBLE (HV),
      .H_FRONT   (HF),
      .H_SYNC    (HS),
      .H_BACK    (HB),
      .V_VISIBLE (VV),
      .V_FRONT   (VF),
      .V_SYNC    (VS),
      .V_BACK    (VB)
   ) dut (
      .I_50MHZ_CLK  (clk),
      .I_RST_N      (rst_n),
      .vga_25clk    (vga_25clk),
      .O_HSYNC      (hsync),
      .O_VSYNC      (vsync),
      .display_data (de),
      .draw_finish  (df),
      .O_PIX_X      (pix_x),
      .O_PIX_Y      (pix_y),
      .O_FRAME_CNT  (frame_cnt)
   );

   // 50 MHz system clock.
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   function automatic out_t actual_out();
      out_t a;
      a.vga = vga_25clk;
      a.hs  = hsync;
      a.vs  = vsync;
      a.de  = de;
      a.df  = df;
      a.x   = pix_x;
      a.y   = pix_y;
      a.fc  = frame_cnt;
      return a;
   endfunction

   // Reference: tick t since release shows pixel index t mod frame size;
   // a frame completes each time index FIN_TICK is reached.
   function automatic out_t model_now();
      out_t o;
      int   t;
      int   p;
      int   h;
      int   v;
      int   frames;
      o = '0;
      o.hs = 1'b1;
      o.vs = 1'b1;
      if (cyc == 0) begin
         return o;
      end
      t      = (cyc - 1) / 2;
      p      = t % FT;
      h      = p % HT;
      v      = p / HT;
      frames = (t >= FIN_TICK) ? ((t - FIN_TICK) / FT + 1) : 0;
      o.vga  = ((cyc - 1) % 2 == 0);
      o.hs   = !((h >= HV + HF) && (h < HV + HF + HS));
      o.vs   = !((v >= VV + VF) && (v < VV + VF + VS));
      o.de   = (h < HV) && (v < VV);
      o.df   = (h == 0) && (v == VV);
      o.x    = o.de ? 10'(h) : 10'd0;
      o.y    = o.de ? 10'(v) : 10'd0;
      o.fc   = fc_base + 16'(frames);
      return o;
   endfunction

   task automatic check_output(input string name, input out_t exp, input out_t act);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cyc=%0d actual=%h required=%h (vga,hs,vs,de,df,x,y,fc)",
                  name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Record sync edges, strobe positions and visible-pixel counts on
   // every pixel tick while measurement is enabled.
   task automatic record_tick();
      int t;
      t = (cyc - 1) / 2;
      if (prev_hs && !hsync) hs_fall.push_back(t);
      if (!prev_hs && hsync) hs_rise.push_back(t);
      if (prev_vs && !vsync) vs_fall.push_back(t);
      if (!prev_vs && vsync) vs_rise.push_back(t);
      prev_hs = hsync;
      prev_vs = vsync;
      if (de) begin
         de_run++;
         cur_last = {pix_x, pix_y};
      end
      if (df) begin
         df_tick.push_back(t);
         de_counts.push_back(de_run);
         last_pix.push_back(cur_last);
         de_run = 0;
      end
   endtask

   // One system cycle: drive reset at the falling edge, let the rising
   // edge happen, sample at the next falling edge.
   task automatic apply_stimulus(input logic rst, input bit use_model);
      rst_n = rst;
      @(posedge clk);
      @(negedge clk);
      if (!rst) begin
         cyc     = 0;
         fc_base = 16'd0;
      end else begin
         cyc++;
      end
      if (use_model) check_output("model", model_now(), actual_out());
      if (measure && rst && ((cyc - 1) % 2 == 0)) record_tick();
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b1);
   endtask

   task automatic run_until_tick(input int t);
      while (cyc < 2 * t + 1) apply_stimulus(1'b1, 1'b1);
   endtask

   vec_t vecs[11];
   out_t r_idle;
   out_t o_tmp;

   initial begin
      rst_n = 1'b0;

      // Reset value, then startup: tick0 (0,0), hold, tick1 (1,0), ...
      r_idle = '0;
      r_idle.hs = 1'b1;
      r_idle.vs = 1'b1;
      for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, r_idle};
      for (int i = 0; i < 6; i++) begin
         o_tmp     = r_idle;
         o_tmp.vga = (i % 2 == 0);
         o_tmp.de  = 1'b1;
         o_tmp.x   = 10'(i / 2);
         vecs[5 + i] = '{1'b1, o_tmp};
      end

      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         apply_stimulus(vecs[i].rst_n, 1'b0);
         check_output($sformatf("vec%0d", i), vecs[i].exp, actual_out());
      end

      // Timing measurements over a little more than two frames.
      apply_stimulus(1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b1);
      measure = 1;
      prev_hs = 1'b1;
      prev_vs = 1'b1;
      run_until_tick(2 * FT + FIN_TICK + 8);
      measure = 0;
      if (hs_fall.size() >= 2 && hs_rise.size() >= 1) begin
         check_int("hsync_first_fall", hs_fall[0], HV + HF);
         check_int("hsync_low_width", hs_rise[0] - hs_fall[0], HS);
         check_int("hsync_period", hs_fall[1] - hs_fall[0], HT);
      end else check_int("hsync_edges_seen", hs_fall.size(), 2);
      if (vs_fall.size() >= 2 && vs_rise.size() >= 1) begin
         check_int("vsync_first_fall", vs_fall[0], (VV + VF) * HT);
         check_int("vsync_low_width", vs_rise[0] - vs_fall[0], VS * HT);
         check_int("vsync_period", vs_fall[1] - vs_fall[0], FT);
      end else check_int("vsync_edges_seen", vs_fall.size(), 2);
      if (df_tick.size() >= 2) begin
         check_int("draw_finish_first", df_tick[0], FIN_TICK);
         check_int("draw_finish_spacing", df_tick[1] - df_tick[0], FT);
         check_int("visible_per_frame", de_counts[1], HV * VV);
         check_int("last_visible_xy", int'(last_pix[1]), int'({10'(HV - 1), 10'(VV - 1)}));
      end else check_int("draw_finish_seen", df_tick.size(), 2);

      // Reset in the middle of the visible area aborts the frame.
      apply_stimulus(1'b0, 1'b1);
      run_until_tick(3 * HT + 5);
      apply_stimulus(1'b0, 1'b1);
      check_int("midreset_frame_cnt", int'(frame_cnt), 0);
      check_int("midreset_no_finish", int'(df), 0);
      apply_stimulus(1'b1, 1'b1);
      check_int("restart_display", int'(de), 1);
      check_int("restart_xy", int'({pix_x, pix_y}), 0);
      run_until_tick(FIN_TICK - 1);
      check_int("no_early_finish_cnt", int'(frame_cnt), 0);
      run_until_tick(FIN_TICK);
      check_int("first_frame_cnt", int'(frame_cnt), 1);

      // Frame counter wrap: preload 0xFFFF mid-frame, next strobe gives 0.
      apply_stimulus(1'b1, 1'b1);
      force dut.frame_cnt = 16'hFFFF;
      fc_base = 16'hFFFE;
      apply_stimulus(1'b1, 1'b1);
      release dut.frame_cnt;
      run_until_tick(FIN_TICK + FT - 1);
      check_int("pre_wrap_cnt", int'(frame_cnt), 16'hFFFF);
      run_until_tick(FIN_TICK + FT);
      check_int("wrap_finish", int'(df), 1);
      check_int("wrap_cnt", int'(frame_cnt), 0);
      run_cycles(4);

      // Random run lengths with random reset pulses of 1..3 cycles.
      for (int k = 0; k < 16; k++) begin
         int len;
         int rlen;
         len  = int'($urandom_range(1, 500));
         rlen = int'($urandom_range(1, 3));
         for (int i = 0; i < rlen; i++) apply_stimulus(1'b0, 1'b1);
         run_cycles(len);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
